// File: rtl/random_range_sampler_pkg.sv
// Shared constants and FSM state encoding for the bounded random sampler.
package random_range_sampler_pkg;

  localparam int DEFAULT_OUT_W     = 10;
  localparam int DEFAULT_MAX_TRIES = 8;
  localparam int RAND_W            = 16;
  localparam int TRY_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/random_range_sampler_mask.sv
// Combinational mask derivation: smallest 2^k-1 that covers L-1.
module range_mask_gen #(
  parameter int OUT_W = 10
) (
  input  logic [OUT_W:0]   l_i,
  output logic [OUT_W-1:0] m_o
);

  logic [OUT_W-1:0] top_val;

  // L is at most 2^OUT_W, so L-1 always fits in OUT_W bits.
  assign top_val = OUT_W'(l_i - (OUT_W+1)'(1));

  always_comb begin
    m_o = top_val;
    for (int i = 0; i < OUT_W; i++) begin
      m_o = m_o | (m_o >> 1);
    end
  end

endmodule

// File: rtl/random_range_sampler.sv
// Rejection sampler: draws masked random words until one falls below the
// latched limit, falling back to C-L after MAX_TRIES misses.
module random_range_sampler
  import random_range_sampler_pkg::*;
#(
  parameter int MAX_TRIES = DEFAULT_MAX_TRIES,
  parameter int OUT_W     = DEFAULT_OUT_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [RAND_W-1:0] RAND_IN,
  input  logic              REQ,
  input  logic [OUT_W:0]    LIMIT,
  output logic [OUT_W-1:0]  RESULT,
  output logic              VALID,
  input  logic              ACK,
  output logic              BUSY,
  output logic              FALLBACK,
  output state_e            dbg_state_o
);

  localparam logic [OUT_W:0]   L_MAX        = {1'b1, {OUT_W{1'b0}}};
  localparam logic [OUT_W:0]   L_ONE        = (OUT_W+1)'(1);
  localparam logic [TRY_W-1:0] LAST_TRY     = TRY_W'(MAX_TRIES - 1);

  state_e           state_q, state_d;
  logic [OUT_W:0]   l_q, l_d, lim_eff;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             primed_q, primed_d;
  logic [OUT_W-1:0] cand_q, mask;
  logic [OUT_W-1:0] result_q, result_d;
  logic             fallback_q, fallback_d;
  logic             valid_q, busy_q;
  logic [OUT_W:0]   cand_ext;

  range_mask_gen #(.OUT_W(OUT_W)) u_mask (
    .l_i (l_q),
    .m_o (mask)
  );

  generate
    if (OUT_W < RAND_W) begin : g_unused
      logic unused_rand_bits;
      assign unused_rand_bits = ^RAND_IN[RAND_W-OUT_W-1:0];
    end
  endgenerate

  assign cand_ext = {1'b0, cand_q};

  always_comb begin
    lim_eff = LIMIT;
    if (LIMIT == '0)       lim_eff = L_ONE;
    else if (LIMIT > L_MAX) lim_eff = L_MAX;
  end

  // The first SAMPLE cycle only primes cand_q with the new mask applied.
  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    tries_d    = tries_q;
    primed_d   = primed_q;
    result_d   = result_q;
    fallback_d = fallback_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          l_d      = lim_eff;
          tries_d  = '0;
          primed_d = 1'b0;
          state_d  = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (!primed_q) begin
          primed_d = 1'b1;
        end else if (cand_ext < l_q) begin
          result_d   = cand_q;
          fallback_d = 1'b0;
          state_d    = ST_HOLD;
        end else if (tries_q == LAST_TRY) begin
          result_d   = OUT_W'(cand_ext - l_q);
          fallback_d = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      ST_HOLD: begin
        if (ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      l_q        <= L_ONE;
      tries_q    <= '0;
      primed_q   <= 1'b0;
      cand_q     <= '0;
      result_q   <= '0;
      fallback_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      tries_q    <= tries_d;
      primed_q   <= primed_d;
      cand_q     <= RAND_IN[RAND_W-1 -: OUT_W] & mask;
      result_q   <= result_d;
      fallback_q <= fallback_d;
      valid_q    <= (state_d == ST_HOLD);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign RESULT      = result_q;
  assign VALID       = valid_q;
  assign BUSY        = busy_q;
  assign FALLBACK    = fallback_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/random_range_sampler.md
RANDOM_RANGE_SAMPLER -- requirements
Module: random_range_sampler

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 8, meaning the number of rejection-sampling attempts before fallback (legal range 1..15).
REQ-002 SHALL have parameter OUT_W, default 10, meaning the RESULT width; the maximum LIMIT is 2^OUT_W.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port RAND_IN, input, 16 bits: free-running pseudo-random word from the upstream 16-bit LFSR generator, new value every cycle.
REQ-006 SHALL have port REQ, input, 1 bit: request for one bounded random value.
REQ-007 SHALL have port LIMIT, input, OUT_W+1 bits: exclusive upper bound, sampled with REQ.
REQ-008 SHALL have port RESULT, output, OUT_W bits: value in [0, LIMIT-1].
REQ-009 SHALL have port VALID, output, 1 bit: RESULT is valid.
REQ-010 SHALL have port ACK, input, 1 bit: consumer has taken RESULT.
REQ-011 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port FALLBACK, output, 1 bit: the current RESULT came from the fallback path; qualified by VALID.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SAMPLE, HOLD.
REQ-014 IDLE: when REQ=1, SHALL latch the effective limit L and go to SAMPLE on the next edge; try counter SHALL be cleared.
REQ-015 Effective limit: LIMIT=0 SHALL be treated as 1; LIMIT>2^OUT_W SHALL be clamped to 2^OUT_W.
REQ-016 Mask M SHALL be the smallest 2^k-1 with M >= L-1 (L=1 gives M=0; L=600 gives M=1023; L=512 gives M=511).
REQ-017 SAMPLE, each cycle: candidate C = RAND_IN[15:16-OUT_W] AND M.
REQ-018 SAMPLE: if C < L, SHALL register RESULT=C and FALLBACK=0, then go to HOLD.
REQ-019 SAMPLE: if C >= L and fewer than MAX_TRIES tries have been used, SHALL increment the try counter and stay in SAMPLE.
REQ-020 SAMPLE: if C >= L on try number MAX_TRIES, SHALL register RESULT=C-L and FALLBACK=1, then go to HOLD. C-L < L is guaranteed because M < 2L.
REQ-021 HOLD: VALID=1, and RESULT/FALLBACK SHALL be held stable until ACK=1 is sampled.
REQ-022 HOLD with ACK=1: next state SHALL be IDLE with VALID=0; a REQ in that same cycle SHALL be ignored.
REQ-023 Latency: REQ sampled at edge n, first-try accept gives VALID=1 after edge n+2; worst case (fallback) gives VALID=1 after edge n+MAX_TRIES+1.
REQ-024 REQ while in SAMPLE or HOLD SHALL be ignored, not queued; changes to LIMIT after latching SHALL have no effect.
REQ-025 ACK while VALID=0 SHALL have no effect.
REQ-026 BUSY SHALL be a registered decode of state; VALID SHALL be registered (no combinational path from any input to any output).

Reset
REQ-027 RST_N=0 at an edge SHALL force state IDLE, RESULT=0, VALID=0, FALLBACK=0, BUSY=0, try counter=0, L=1.
REQ-028 Reset asserted mid-SAMPLE or mid-HOLD SHALL abandon the request with no VALID pulse; the first REQ after release SHALL behave as from power-up.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE/SAMPLE/HOLD), the default OUT_W and MAX_TRIES constants, and the RAND_IN width (16).
REQ-030 Mask derivation (L to M) SHALL be a separate combinational sub-module, range_mask_gen; all other logic stays in random_range_sampler.

Verification
REQ-031 LIMIT=1, REQ pulse at edge 0 -> RESULT=0, FALLBACK=0, VALID=1 after edge 2; ACK -> VALID=0 and BUSY=0 next edge.
REQ-032 LIMIT=600, RAND_IN forced to 0xFFC0 (C=1023) for 8 cycles -> after edge 9 RESULT=423, FALLBACK=1, VALID=1.
REQ-033 LIMIT=600, RAND_IN=0xFFC0 then 0x4B00 (C=300) on the second try -> after edge 3 RESULT=300, FALLBACK=0.
REQ-034 LIMIT=0 and LIMIT=2047 -> results 0 and within [0,1023] respectively; LIMIT changed to 5 during SAMPLE does not alter the bound.
REQ-035 RST_N=0 in HOLD with ACK never asserted -> VALID=0 next edge; REQ in the HOLD/ACK cycle ignored.
REQ-036 Free-running LFSR stimulus, 10000 requests with random LIMIT -> every RESULT < effective L, and VALID is always followed by stable RESULT until ACK.
